mips_multicycle_sequencer: RTL and testbench
============================================

Name: mips_multicycle_sequencer

Overview:
- Parametrised successor to the single-cycle control path: a multi-cycle FSM that sequences fetch, decode, execute, memory and writeback over several clocks instead of one.
- Drives the existing datapath control signals, plus PC/IR write enables and variable-latency memory request/ready handshakes.
- Sits between the instruction register opcode and the datapath stage modules in the next-generation core top.
- Adds halt, illegal-opcode detection, memory timeout and performance counters.

Parameters:
- TIMEOUT, 15: max cycles a memory request may wait for ready before bus error; range 1..255.
- CNT_W, 32: width of cycle and retired-instruction counters.
- ENABLE_ADDI, 1: when 0, opcode 001000 is illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the IR; valid from DECODE onward.
- aluZero  in  1  ALU zero flag, valid in EXECUTE.
- halt  in  1  stop request.
- imemReady  in  1  instruction memory ready.
- dmemReady  in  1  data memory ready.
- imemReq  out  1  instruction fetch request.
- dmemReq  out  1  data access request.
- irWrite  out  1  latch instruction into the IR.
- pcWrite  out  1  update PC.
- regDst  out  1  rd vs rt destination.
- jump  out  1  PC source is the jump target.
- branchC  out  2  00 none, 01 beq, 10 bne.
- memRead  out  1  data read.
- memToReg  out  1  writeback from memory.
- aluOp  out  2  00 add, 01 sub, 10 funct.
- memWrite  out  1  data write.
- aluSrc  out  1  immediate operand.
- regWrite  out  1  register file write.
- halted  out  1  FSM in HALT.
- illegalOp  out  1  sticky: halted on an unknown opcode.
- busError  out  1  sticky: halted on a memory timeout.
- cycleCount  out  CNT_W  cycles since reset.
- instrCount  out  CNT_W  retired instructions.

Behaviour:
- Reset (synchronous):
  - Next state is FETCH.
  - All control outputs, halted, illegalOp and busError are 0.
  - Both counters are 0.
  - Reset wins over every other event, including mid-MEMORY with dmemReq high: dmemReq drops the cycle after the reset edge.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Control outputs are Moore-style decodes of state plus latched opcode, except the ready-qualified strobes below.
- FETCH:
  - If halt=1, go to HALT without raising imemReq.
  - Otherwise imemReq=1.
  - When imemReady=1, irWrite=1 in that same cycle and next state is DECODE.
- DECODE (1 cycle):
  - j (000010): pcWrite=1, jump=1; retire; go to FETCH.
  - Recognised opcodes go to EXECUTE: R (000000), lw (100011), sw (101011), beq (000100), bne (000101), addi (001000) when ENABLE_ADDI=1.
  - Any other opcode: illegalOp is set; go to HALT.
- EXECUTE (1 cycle):
  - R: aluOp=10; go to WRITEBACK.
  - addi, lw, sw: aluSrc=1, aluOp=00.
    - addi goes to WRITEBACK.
    - lw and sw go to MEMORY.
  - beq/bne: aluOp=01, branchC=01/10, pcWrite=1. The datapath selects target or PC+4 using aluZero. Retire; go to FETCH.
- MEMORY:
  - dmemReq=1, aluSrc=1, aluOp=00, and memRead (lw) or memWrite (sw) are held steady until dmemReady=1.
  - On ready: lw goes to WRITEBACK; sw asserts pcWrite, retires, and goes to FETCH.
- WRITEBACK (1 cycle): regWrite=1, pcWrite=1, retire, go to FETCH.
  - R: regDst=1.
  - lw: memToReg=1.
  - addi: both 0.
- Timeout:
  - A wait counter counts cycles a request is outstanding without ready. It clears on state entry.
  - On the TIMEOUT-th cycle without ready (the request has been high TIMEOUT cycles), busError is set and next state is HALT.
  - A ready arriving in that same cycle takes priority: no error.
- Cycle counts at zero wait states: j=2, beq/bne=3, R/addi/sw=4, lw=5. Each cycle of memory wait adds 1.
- HALT: all control outputs 0, halted=1. Leaves only via reset. halt is ignored outside FETCH.
- Counters:
  - cycleCount increments every non-reset cycle, including HALT.
  - instrCount increments on each retire, i.e. each pcWrite.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Zero-wait R-type, opcode 000000, ready tied 1 → irWrite in cycle 0, regWrite + regDst + pcWrite in cycle 3; instrCount=1 after 4 cycles; next imemReq in cycle 4.
- lw with dmemReady after 3 wait cycles → memRead/dmemReq high for 4 cycles; WRITEBACK with memToReg=1; 8 cycles total; instrCount=1.
- beq with aluZero=1, then bne with aluZero=0 → branchC=01 then 10, pcWrite in EXECUTE; 6 cycles total; instrCount=2.
- Opcode 111111 → illegalOp=1 and halted=1 from cycle 2; no further imemReq; cycleCount keeps counting; reset clears all.
- sw with dmemReady never asserted, TIMEOUT=15 → dmemReq high for 15 cycles, then busError=1 and halted=1; with ready on cycle 15 instead → no error, FETCH.
- Reset asserted mid-MEMORY → cycle after the edge: FETCH, dmemReq=0, counters 0. Separately, halt=1 in FETCH → HALT with no imemReq.

Source files
------------

// File: rtl/mips_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// mips_multicycle_sequencer
//
// Multi-cycle control FSM for the MIPS core. It walks each instruction through
// FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK, drives the datapath
// control strobes as Moore decodes of state plus the latched opcode, handles
// variable-latency memory handshakes with a timeout, and keeps saturating
// cycle / retired-instruction counters.
//
// Parameters
//   TIMEOUT     : cycles a memory request may wait for ready (1..255)
//   CNT_W       : width of cycleCount / instrCount
//   ENABLE_ADDI : when 0, addi (001000) is treated as illegal
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   opcode                : IR[31:26], valid from DECODE onward
//   aluZero               : ALU zero flag (consumed by the datapath PC mux)
//   halt                  : stop request, honoured only in FETCH
//   imemReady, dmemReady  : memory ready handshakes
//   imemReq, dmemReq      : memory requests
//   irWrite, pcWrite      : IR / PC write enables
//   regDst, jump, branchC, memRead, memToReg, aluOp, memWrite, aluSrc,
//   regWrite              : datapath controls
//   halted                : FSM sits in HALT
//   illegalOp, busError   : sticky halt causes
//   cycleCount, instrCount: saturating performance counters
// ---------------------------------------------------------------------------
module mips_multicycle_sequencer #(
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 32,
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             aluZero,
  input  logic             halt,
  input  logic             imemReady,
  input  logic             dmemReady,
  output logic             imemReq,
  output logic             dmemReq,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             regDst,
  output logic             jump,
  output logic [1:0]       branchC,
  output logic             memRead,
  output logic             memToReg,
  output logic [1:0]       aluOp,
  output logic             memWrite,
  output logic             aluSrc,
  output logic             regWrite,
  output logic             halted,
  output logic             illegalOp,
  output logic             busError,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] instrCount
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // Wait count value seen on the TIMEOUT-th cycle without ready.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  state_t           r_state, w_next;
  logic [5:0]       r_op;
  logic [7:0]       r_wait;
  logic             r_ill, r_bus;
  logic [CNT_W-1:0] r_cyc, r_ins;
  logic             w_set_ill, w_set_bus, w_wait_inc;

  // aluZero steers the PC mux inside the datapath; the sequencer only
  // raises pcWrite, so the flag is carried on the port without being decoded.
  logic w_unused_aluzero;
  assign w_unused_aluzero = aluZero;

  // ---- state / status / counter registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_ill   <= 1'b0;
      r_bus   <= 1'b0;
      r_cyc   <= '0;
      r_ins   <= '0;
    end else begin
      r_state <= w_next;
      // The wait counter restarts whenever a new state is entered.
      if (w_next != r_state) r_wait <= '0;
      else if (w_wait_inc)   r_wait <= r_wait + 8'd1;
      if (w_set_ill) r_ill <= 1'b1;
      if (w_set_bus) r_bus <= 1'b1;
      if (!(&r_cyc))           r_cyc <= r_cyc + CNT_W'(1);
      if (pcWrite && !(&r_ins)) r_ins <= r_ins + CNT_W'(1);
    end
  end

  // Opcode is held for EXECUTE/MEMORY/WRITEBACK; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) r_op <= opcode;
  end

  // ---- next-state and control decode ----
  always_comb begin
    w_next     = r_state;
    w_set_ill  = 1'b0;
    w_set_bus  = 1'b0;
    w_wait_inc = 1'b0;
    imemReq    = 1'b0;
    dmemReq    = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    regDst     = 1'b0;
    jump       = 1'b0;
    branchC    = 2'b00;
    memRead    = 1'b0;
    memToReg   = 1'b0;
    aluOp      = 2'b00;
    memWrite   = 1'b0;
    aluSrc     = 1'b0;
    regWrite   = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (halt) begin
          w_next = S_HALT;
        end else begin
          imemReq = 1'b1;
          // Ready in the timeout cycle still wins over the bus error.
          if (imemReady) begin
            irWrite = 1'b1;
            w_next  = S_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            w_set_bus = 1'b1;
            w_next    = S_HALT;
          end else begin
            w_wait_inc = 1'b1;
          end
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_J: begin
            pcWrite = 1'b1;
            jump    = 1'b1;
            w_next  = S_FETCH;
          end
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE: w_next = S_EXECUTE;
          OP_ADDI: begin
            w_set_ill = !ENABLE_ADDI;
            w_next    = ENABLE_ADDI ? S_EXECUTE : S_HALT;
          end
          default: begin
            w_set_ill = 1'b1;
            w_next    = S_HALT;
          end
        endcase
      end
      S_EXECUTE: begin
        case (r_op)
          OP_R: begin
            aluOp  = 2'b10;
            w_next = S_WRITEBACK;
          end
          OP_BEQ, OP_BNE: begin
            aluOp   = 2'b01;
            branchC = (r_op == OP_BEQ) ? 2'b01 : 2'b10;
            pcWrite = 1'b1;
            w_next  = S_FETCH;
          end
          OP_LW, OP_SW: begin
            aluSrc = 1'b1;
            w_next = S_MEMORY;
          end
          default: begin
            // Only addi reaches this arm.
            aluSrc = 1'b1;
            w_next = S_WRITEBACK;
          end
        endcase
      end
      S_MEMORY: begin
        dmemReq  = 1'b1;
        aluSrc   = 1'b1;
        memRead  = (r_op == OP_LW);
        memWrite = (r_op != OP_LW);
        if (dmemReady) begin
          if (r_op == OP_LW) begin
            w_next = S_WRITEBACK;
          end else begin
            pcWrite = 1'b1;
            w_next  = S_FETCH;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_set_bus = 1'b1;
          w_next    = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WRITEBACK: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        regDst   = (r_op == OP_R);
        memToReg = (r_op == OP_LW);
        w_next   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign illegalOp  = r_ill;
  assign busError   = r_bus;
  assign cycleCount = r_cyc;
  assign instrCount = r_ins;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
module tb_mips_multicycle_sequencer;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BAD  = 6'b111111;

  // Bit positions of the packed output vector compared each cycle.
  localparam logic [17:0] IMEM = 18'h20000;
  localparam logic [17:0] DMEM = 18'h10000;
  localparam logic [17:0] IRW  = 18'h08000;
  localparam logic [17:0] PCW  = 18'h04000;
  localparam logic [17:0] RDST = 18'h02000;
  localparam logic [17:0] JMP  = 18'h01000;
  localparam logic [17:0] BRQ  = 18'h00400;
  localparam logic [17:0] BRN  = 18'h00800;
  localparam logic [17:0] MRD  = 18'h00200;
  localparam logic [17:0] M2R  = 18'h00100;
  localparam logic [17:0] ASUB = 18'h00040;
  localparam logic [17:0] AFUN = 18'h00080;
  localparam logic [17:0] MWR  = 18'h00020;
  localparam logic [17:0] ASRC = 18'h00010;
  localparam logic [17:0] RW   = 18'h00008;
  localparam logic [17:0] HLT  = 18'h00004;
  localparam logic [17:0] ILL  = 18'h00002;
  localparam logic [17:0] BUS  = 18'h00001;
  localparam logic [17:0] NONE = 18'h00000;

  logic       clk, reset, aluZero, halt, imemReady, dmemReady;
  logic [5:0] opcode;
  logic       imemReq, dmemReq, irWrite, pcWrite, regDst, jump;
  logic [1:0] branchC, aluOp;
  logic       memRead, memToReg, memWrite, aluSrc, regWrite;
  logic       halted, illegalOp, busError;
  logic [7:0] cycleCount, instrCount;
  logic [17:0] outs;

  mips_multicycle_sequencer #(
    .TIMEOUT(15), .CNT_W(8), .ENABLE_ADDI(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .aluZero(aluZero),
    .halt(halt), .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq), .dmemReq(dmemReq), .irWrite(irWrite),
    .pcWrite(pcWrite), .regDst(regDst), .jump(jump), .branchC(branchC),
    .memRead(memRead), .memToReg(memToReg), .aluOp(aluOp),
    .memWrite(memWrite), .aluSrc(aluSrc), .regWrite(regWrite),
    .halted(halted), .illegalOp(illegalOp), .busError(busError),
    .cycleCount(cycleCount), .instrCount(instrCount)
  );

  assign outs = {imemReq, dmemReq, irWrite, pcWrite, regDst, jump, branchC,
                 memRead, memToReg, aluOp, memWrite, aluSrc, regWrite,
                 halted, illegalOp, busError};

  typedef struct {
    string       tag;
    logic        rst;
    logic [5:0]  op;
    logic        z, h, ir, dr;
    logic [17:0] exp;
    int          icnt;
  } vec_t;

  typedef struct {
    string       tag;
    int          idx;
    logic        chk;
    logic [17:0] exp;
    int          icnt;
    int          cyc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_model = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void v_add(string tag, logic rst, logic [5:0] op,
                                logic z, logic h, logic ir, logic dr,
                                logic [17:0] exp, int icnt);
    vec_t v;
    v.tag = tag; v.rst = rst; v.op = op; v.z = z; v.h = h;
    v.ir = ir; v.dr = dr; v.exp = exp; v.icnt = icnt;
    vecs.push_back(v);
  endfunction

  task automatic check_one();
    sb_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
      return;
    end
    e = sb.pop_front();
    if (!e.chk) return;
    checks++;
    if (outs !== e.exp) begin
      errors++;
      $display("FAIL %s[%0d] outputs: got %05h want %05h", e.tag, e.idx, outs, e.exp);
    end
    checks++;
    if (int'(instrCount) != e.icnt) begin
      errors++;
      $display("FAIL %s[%0d] instrCount: got %0d want %0d", e.tag, e.idx, instrCount, e.icnt);
    end
    checks++;
    if (int'(cycleCount) != e.cyc) begin
      errors++;
      $display("FAIL %s[%0d] cycleCount: got %0d want %0d", e.tag, e.idx, cycleCount, e.cyc);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = R; aluZero = 1'b0; halt = 1'b0;
    imemReady = 1'b1; dmemReady = 1'b1;

    // Reset
    v_add("rst", 1, R, 0, 0, 1, 1, NONE, 0);
    v_add("rst", 1, R, 0, 0, 1, 1, NONE, 0);
    // Zero-wait R-type
    v_add("R_F",  0, R, 0, 0, 1, 1, IMEM | IRW, 0);
    v_add("R_D",  0, R, 0, 0, 1, 1, NONE, 0);
    v_add("R_E",  0, R, 0, 0, 1, 1, AFUN, 0);
    v_add("R_WB", 0, R, 0, 0, 1, 1, RW | PCW | RDST, 0);
    // lw with three data wait states
    v_add("LW_F", 0, LW, 0, 0, 1, 1, IMEM | IRW, 1);
    v_add("LW_D", 0, LW, 0, 0, 1, 1, NONE, 1);
    v_add("LW_E", 0, LW, 0, 0, 1, 1, ASRC, 1);
    for (int i = 0; i < 3; i++) v_add("LW_MW", 0, LW, 0, 0, 1, 0, DMEM | MRD | ASRC, 1);
    v_add("LW_MR",  0, LW, 0, 0, 1, 1, DMEM | MRD | ASRC, 1);
    v_add("LW_WB",  0, LW, 0, 0, 1, 1, RW | PCW | M2R, 1);
    // beq (zero) then bne (not zero)
    v_add("BEQ_F", 0, BEQ, 1, 0, 1, 1, IMEM | IRW, 2);
    v_add("BEQ_D", 0, BEQ, 1, 0, 1, 1, NONE, 2);
    v_add("BEQ_E", 0, BEQ, 1, 0, 1, 1, ASUB | BRQ | PCW, 2);
    v_add("BNE_F", 0, BNE, 0, 0, 1, 1, IMEM | IRW, 3);
    v_add("BNE_D", 0, BNE, 0, 0, 1, 1, NONE, 3);
    v_add("BNE_E", 0, BNE, 0, 0, 1, 1, ASUB | BRN | PCW, 3);
    // addi with halt held outside FETCH (ignored)
    v_add("ADDI_F",  0, ADDI, 0, 0, 1, 1, IMEM | IRW, 4);
    v_add("ADDI_D",  0, ADDI, 0, 1, 1, 1, NONE, 4);
    v_add("ADDI_E",  0, ADDI, 0, 1, 1, 1, ASRC, 4);
    v_add("ADDI_WB", 0, ADDI, 0, 1, 1, 1, RW | PCW, 4);
    // Zero-wait sw
    v_add("SW_F", 0, SW, 0, 0, 1, 1, IMEM | IRW, 5);
    v_add("SW_D", 0, SW, 0, 0, 1, 1, NONE, 5);
    v_add("SW_E", 0, SW, 0, 0, 1, 1, ASRC, 5);
    v_add("SW_M", 0, SW, 0, 0, 1, 1, DMEM | MWR | ASRC | PCW, 5);
    // Jump
    v_add("J_F", 0, J, 0, 0, 1, 1, IMEM | IRW, 6);
    v_add("J_D", 0, J, 0, 0, 1, 1, PCW | JMP, 6);
    // Instruction fetch with two wait states, then a jump
    v_add("IW_F",  0, J, 0, 0, 0, 1, IMEM, 7);
    v_add("IW_F",  0, J, 0, 0, 0, 1, IMEM, 7);
    v_add("IW_FR", 0, J, 0, 0, 1, 1, IMEM | IRW, 7);
    v_add("IW_D",  0, J, 0, 0, 1, 1, PCW | JMP, 7);
    // sw that never sees dmemReady: 15 request cycles then bus error
    v_add("TO_F", 0, SW, 0, 0, 1, 0, IMEM | IRW, 8);
    v_add("TO_D", 0, SW, 0, 0, 1, 0, NONE, 8);
    v_add("TO_E", 0, SW, 0, 0, 1, 0, ASRC, 8);
    for (int i = 0; i < 15; i++) v_add("TO_M", 0, SW, 0, 0, 1, 0, DMEM | MWR | ASRC, 8);
    for (int i = 0; i < 3; i++)  v_add("TO_H", 0, SW, 0, 1, 1, 1, HLT | BUS, 8);
    v_add("rst", 1, SW, 0, 0, 1, 1, NONE, 0);
    // sw whose ready arrives on the 15th request cycle: no error
    v_add("RDY_F", 0, SW, 0, 0, 1, 0, IMEM | IRW, 0);
    v_add("RDY_D", 0, SW, 0, 0, 1, 0, NONE, 0);
    v_add("RDY_E", 0, SW, 0, 0, 1, 0, ASRC, 0);
    for (int i = 0; i < 14; i++) v_add("RDY_MW", 0, SW, 0, 0, 1, 0, DMEM | MWR | ASRC, 0);
    v_add("RDY_M15", 0, SW, 0, 0, 1, 1, DMEM | MWR | ASRC | PCW, 0);
    // Illegal opcode
    v_add("ILL_F", 0, BAD, 0, 0, 1, 1, IMEM | IRW, 1);
    v_add("ILL_D", 0, BAD, 0, 0, 1, 1, NONE, 1);
    for (int i = 0; i < 3; i++) v_add("ILL_H", 0, BAD, 0, 0, 1, 1, HLT | ILL, 1);
    v_add("rst", 1, R, 0, 0, 1, 1, NONE, 0);
    // Reset in the middle of a data access
    v_add("MR_F", 0, LW, 0, 0, 1, 0, IMEM | IRW, 0);
    v_add("MR_D", 0, LW, 0, 0, 1, 0, NONE, 0);
    v_add("MR_E", 0, LW, 0, 0, 1, 0, ASRC, 0);
    v_add("MR_M", 0, LW, 0, 0, 1, 0, DMEM | MRD | ASRC, 0);
    v_add("rst",  1, LW, 0, 0, 1, 0, NONE, 0);
    v_add("MR_POST", 0, LW, 0, 0, 0, 0, IMEM, 0);
    // halt in FETCH
    v_add("HF_F", 0, R, 0, 1, 1, 1, NONE, 0);
    v_add("HF_H", 0, R, 0, 0, 1, 1, HLT, 0);
    v_add("HF_H", 0, R, 0, 0, 1, 1, HLT, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      sb_t e;
      @(posedge clk);
      #1;
      reset = vecs[k].rst; opcode = vecs[k].op; aluZero = vecs[k].z;
      halt = vecs[k].h; imemReady = vecs[k].ir; dmemReady = vecs[k].dr;
      e.tag = vecs[k].tag; e.idx = k; e.chk = !vecs[k].rst;
      e.exp = vecs[k].exp; e.icnt = vecs[k].icnt; e.cyc = cyc_model;
      sb.push_back(e);
      if (vecs[k].rst) cyc_model = 0;
      else if (cyc_model < 255) cyc_model++;
      @(negedge clk);
      check_one();
    end

    // Long HALT dwell: cycleCount (8 bits here) must stop at all-ones.
    repeat (300) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cycleCount !== 8'hff) begin
      errors++;
      $display("FAIL cyc_saturate: got %0d want 255", cycleCount);
    end
    checks++;
    if (outs !== HLT) begin
      errors++;
      $display("FAIL halt_dwell outputs: got %05h want %05h", outs, HLT);
    end

    // Reset out of HALT clears everything and restarts fetching.
    @(posedge clk); #1;
    reset = 1'b1; halt = 1'b0; imemReady = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== (IMEM | IRW) || cycleCount !== 8'd0 || instrCount !== 8'd0) begin
      errors++;
      $display("FAIL post_halt_reset: got outs=%05h cyc=%0d ins=%0d want outs=%05h cyc=0 ins=0",
               outs, cycleCount, instrCount, IMEM | IRW);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
